// File: rtl/fb_pkg.sv
// Shared types and constants for the 160x120 RGB332 frame buffer port arbiter.
package fb_pkg;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam addr_t FB_LAST = addr_t'(FB_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;

  // RGB332 field positions
  localparam int RED_HI = 7, RED_LO = 5;
  localparam int GRN_HI = 4, GRN_LO = 2;
  localparam int BLU_HI = 1, BLU_LO = 0;

  function automatic logic in_range(addr_t a);
    return a <= FB_LAST;
  endfunction

  function automatic logic [2:0] red_of(color_t c);
    return c[RED_HI:RED_LO];
  endfunction

  function automatic logic [2:0] green_of(color_t c);
    return c[GRN_HI:GRN_LO];
  endfunction

  function automatic logic [1:0] blue_of(color_t c);
    return c[BLU_HI:BLU_LO];
  endfunction
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester and RAM-side signals of the frame buffer arbiter.
interface fb_port_arbiter_if;
  import fb_pkg::*;

  logic   disp_req;
  addr_t  disp_addr;
  color_t disp_rdata;
  logic   disp_rvalid;
  logic   wr_req;
  addr_t  wr_addr;
  color_t wr_data;
  logic   wr_ack;
  logic   clr_start;
  color_t clr_color;
  logic   clr_busy;
  logic   mem_en;
  logic   mem_we;
  addr_t  mem_addr;
  color_t mem_wdata;
  color_t mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    output disp_rdata, disp_rvalid, wr_ack, clr_busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    input  disp_rdata, disp_rvalid, wr_ack, clr_busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_clear_seq.sv
// Full-frame clear sequencer: address counter, latched fill colour and busy state.
module fb_clear_seq
  import fb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   step,
  input  color_t color_in,
  output logic   busy,
  output addr_t  addr,
  output color_t color
);
  clr_state_e state_q, state_d;
  logic       last;

  assign last = (addr == FB_LAST);
  assign busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start)        state_d = CLEAR;
      CLEAR: if (step && last) state_d = IDLE;
    endcase
  end

  // Counter parks on the last entry so it can never wrap past the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr    <= '0;
      color   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        addr  <= '0;
        color <= color_in;
      end else if (state_q == CLEAR && step && !last) begin
        addr  <= addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: display reads > clear writes > game writes.
module fb_port_arbiter
  import fb_pkg::*;
(
  input logic clk,
  input logic rst,
  fb_port_arbiter_if.slave bus
);
  logic   clr_busy, clr_step;
  addr_t  clr_addr;
  color_t clr_color_q;
  logic   [1:0] vld_pipe;
  logic   oor_q;

  fb_clear_seq u_clr (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.clr_start),
    .step     (clr_step),
    .color_in (bus.clr_color),
    .busy     (clr_busy),
    .addr     (clr_addr),
    .color    (clr_color_q)
  );

  assign bus.clr_busy    = clr_busy;
  assign bus.disp_rvalid = vld_pipe[1];

  // Grants are gated by rst so the RAM port goes quiet the moment reset hits.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.wr_ack    = 1'b0;
    clr_step      = 1'b0;
    if (!rst) begin
      if (bus.disp_req) begin
        bus.mem_addr = bus.disp_addr;
        bus.mem_en   = in_range(bus.disp_addr);
      end else if (clr_busy) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = clr_addr;
        bus.mem_wdata = clr_color_q;
        clr_step      = 1'b1;
      end else if (bus.wr_req && !bus.clr_start) begin
        bus.wr_ack    = 1'b1;
        bus.mem_addr  = bus.wr_addr;
        bus.mem_wdata = bus.wr_data;
        bus.mem_en    = in_range(bus.wr_addr);
        bus.mem_we    = in_range(bus.wr_addr);
      end
    end
  end

  // Read return: RAM data lands one cycle after the grant, registered the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe       <= '0;
      oor_q          <= 1'b0;
      bus.disp_rdata <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], bus.disp_req};
      oor_q    <= bus.disp_req && !in_range(bus.disp_addr);
      if (vld_pipe[0])
        bus.disp_rdata <= oor_q ? '0 : bus.mem_rdata;
    end
  end
endmodule
